// File: rtl/controlador_display_7seg_param.sv
// Multiplexed N-digit 7-segment driver: refresh prescaler, hex decode, leading-zero blanking, PWM dimming.
// Pins are registered, 1 cycle behind the digit index and PWM phase. No backpressure; data waits in a shadow until a sweep boundary.
module controlador_display_7seg_param #(
  parameter int NUM_DIGITOS       = 4,
  parameter int CLK_HZ            = 100000000,
  parameter int REFRESCO_HZ       = 1000,
  parameter int BRILLO_BITS       = 4,
  parameter bit ANODO_ACTIVO_BAJO = 1'b1,
  parameter bit SEG_ACTIVO_BAJO   = 1'b1
) (
  input  logic                     i_Reloj,
  input  logic                     i_Reset,
  input  logic [4*NUM_DIGITOS-1:0] i_Datos,
  input  logic [NUM_DIGITOS-1:0]   i_Puntos,
  input  logic [NUM_DIGITOS-1:0]   i_Habilitar_Digito,
  input  logic                     i_Suprimir_Ceros,
  input  logic [BRILLO_BITS-1:0]   i_Brillo,
  input  logic                     i_Cargar,
  output logic [6:0]               o_Segmentos,
  output logic                     o_Punto,
  output logic [NUM_DIGITOS-1:0]   o_Anodos,
  output logic                     o_Fin_Barrido
);

  localparam int SUB_DIV = CLK_HZ / (REFRESCO_HZ * (2 ** BRILLO_BITS));
  localparam int PRE_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITOS);

  localparam logic [PRE_W-1:0]       PRE_MAX  = PRE_W'(SUB_DIV - 1);
  localparam logic [IDX_W-1:0]       IDX_MAX  = IDX_W'(NUM_DIGITOS - 1);
  localparam logic [NUM_DIGITOS-1:0] AN_MASK  = {NUM_DIGITOS{ANODO_ACTIVO_BAJO}};
  localparam logic [6:0]             SEG_MASK = {7{SEG_ACTIVO_BAJO}};
  localparam logic [NUM_DIGITOS-1:0] ONE_HOT0 = NUM_DIGITOS'(1);

  generate
    if (SUB_DIV < 1) begin : g_sub_div_check
      $error("controlador_display_7seg_param: CLK_HZ too low for REFRESCO_HZ * 2^BRILLO_BITS");
    end
    if (NUM_DIGITOS < 2 || NUM_DIGITOS > 8) begin : g_digits_check
      $error("controlador_display_7seg_param: NUM_DIGITOS must be 2..8");
    end
  endgenerate

  typedef struct packed {
    logic [4*NUM_DIGITOS-1:0] datos;
    logic [NUM_DIGITOS-1:0]   puntos;
    logic [NUM_DIGITOS-1:0]   habil;
    logic                     suprimir;
  } frame_t;

  logic [PRE_W-1:0]       pre_cnt;
  logic [BRILLO_BITS-1:0] pwm_cnt;
  logic [IDX_W-1:0]       idx;
  logic                   sub_tick;
  logic                   slot_tick;
  logic                   wrap;
  logic                   dead;

  frame_t shadow;
  frame_t active;
  frame_t captured;

  logic [NUM_DIGITOS-1:0] blank;
  logic                   lead;
  logic [3:0]             nibble;
  logic                   lit;
  logic [NUM_DIGITOS-1:0] sel;
  logic [6:0]             seg_on;
  logic                   dp_on;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign sub_tick  = (pre_cnt == PRE_MAX);
  assign slot_tick = sub_tick && (&pwm_cnt);
  assign wrap      = slot_tick && (idx == IDX_MAX);
  assign dead      = (pre_cnt == '0) && (pwm_cnt == '0);

  assign captured = '{datos: i_Datos, puntos: i_Puntos, habil: i_Habilitar_Digito,
                      suprimir: i_Suprimir_Ceros};

  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      idx     <= '0;
    end else begin
      pre_cnt <= sub_tick ? '0 : pre_cnt + 1'b1;
      if (sub_tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // A load on the wrap cycle lands in the shadow only; active takes the previous shadow.
  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (i_Cargar) shadow <= captured;
      if (wrap) active <= shadow;
    end
  end

  // Walk from the most significant digit down; a nonzero nibble or a lit point ends the blank run.
  always_comb begin
    blank = '0;
    lead  = active.suprimir;
    for (int k = NUM_DIGITOS - 1; k >= 1; k--) begin
      lead     = lead && (active.datos[4*k +: 4] == 4'h0) && !active.puntos[k];
      blank[k] = lead;
    end
  end

  always_comb begin
    nibble = active.datos[4*idx +: 4];
    lit    = active.habil[idx] && !blank[idx] && (pwm_cnt <= i_Brillo) && !dead;
    sel    = lit ? (ONE_HOT0 << idx) : '0;
    seg_on = lit ? hex_to_seg(nibble) : 7'h00;
    dp_on  = lit && active.puntos[idx];
  end

  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      o_Anodos      <= AN_MASK;
      o_Segmentos   <= SEG_MASK;
      o_Punto       <= SEG_ACTIVO_BAJO;
      o_Fin_Barrido <= 1'b0;
    end else begin
      o_Anodos      <= sel ^ AN_MASK;
      o_Segmentos   <= seg_on ^ SEG_MASK;
      o_Punto       <= dp_on ^ SEG_ACTIVO_BAJO;
      o_Fin_Barrido <= wrap;
    end
  end

endmodule

// File: tb/tb_controlador_display_7seg_param.sv
// Scoreboard bench: a cycle-count reference model predicts every pin value; a negedge monitor compares.
module tb_controlador_display_7seg_param;

  localparam int N     = 4;
  localparam int SLOT  = 16;
  localparam int SWEEP = 64;
  localparam int SUBD  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] datos;
  logic [3:0]  puntos;
  logic [3:0]  habil;
  logic        suprimir;
  logic [1:0]  brillo;
  logic        cargar;
  logic [6:0]  segmentos;
  logic        punto;
  logic [3:0]  anodos;
  logic        fin_barrido;

  always #5 clk = ~clk;

  controlador_display_7seg_param #(
    .NUM_DIGITOS(N), .CLK_HZ(1600), .REFRESCO_HZ(100), .BRILLO_BITS(2),
    .ANODO_ACTIVO_BAJO(1'b1), .SEG_ACTIVO_BAJO(1'b1)
  ) dut (
    .i_Reloj(clk), .i_Reset(rst), .i_Datos(datos), .i_Puntos(puntos),
    .i_Habilitar_Digito(habil), .i_Suprimir_Ceros(suprimir), .i_Brillo(brillo),
    .i_Cargar(cargar), .o_Segmentos(segmentos), .o_Punto(punto),
    .o_Anodos(anodos), .o_Fin_Barrido(fin_barrido)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       pt;
    logic       fin;
    bit         seg_care;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: cycles elapsed since reset, shadow and active frames.
  int          s;
  logic [15:0] sh_d, ac_d;
  logic [3:0]  sh_p, ac_p, sh_e, ac_e;
  logic        sh_s, ac_s;

  function automatic exp_t predict(input int c);
    exp_t e;
    int d, sub, pwm, nib;
    bit dead, sup, lit;
    d    = (c / SLOT) % N;
    sub  = c % SLOT;
    pwm  = sub / SUBD;
    dead = (sub == 0);
    sup  = ac_s && (d >= 1) && ((ac_d >> (4 * d)) == 16'h0) && ((ac_p >> d) == 4'h0);
    lit  = ac_e[d] && !sup && (pwm <= int'(brillo)) && !dead;
    nib  = int'((ac_d >> (4 * d)) & 16'hF);
    e.an       = lit ? ~(4'b0001 << d) : 4'hF;
    e.seg      = lit ? ~hex7[nib] : 7'h7F;
    e.pt       = lit ? ~ac_p[d] : 1'b1;
    e.fin      = (c % SWEEP == SWEEP - 1);
    e.seg_care = !dead;
    return e;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    if (rst) begin
      s = 0;
      sh_d = '0; sh_p = '0; sh_e = '0; sh_s = 1'b0;
      ac_d = '0; ac_p = '0; ac_e = '0; ac_s = 1'b0;
      e = '{an: 4'hF, seg: 7'h7F, pt: 1'b1, fin: 1'b0, seg_care: 1'b1};
    end else begin
      e = predict(s);
      if (s % SWEEP == SWEEP - 1) begin
        ac_d = sh_d; ac_p = sh_p; ac_e = sh_e; ac_s = sh_s;
      end
      if (cargar) begin
        sh_d = datos; sh_p = puntos; sh_e = habil; sh_s = suprimir;
      end
      s++;
    end
    sb.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("anodos", 32'(anodos), 32'(e.an));
      check("fin_barrido", 32'(fin_barrido), 32'(e.fin));
      if (e.seg_care) begin
        check("segmentos", 32'(segmentos), 32'(e.seg));
        check("punto", 32'(punto), 32'(e.pt));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en,
                      input logic sup);
    datos = d; puntos = p; habil = en; suprimir = sup; cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * SWEEP; i++) begin
      if (s % SWEEP == ph) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_phase: phase %0d not reached, model cycle %0d", ph, s);
    end
  endtask

  initial begin
    rst = 1'b1; datos = '0; puntos = '0; habil = '0; suprimir = 1'b0;
    brillo = 2'd3; cargar = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(130);

    load(16'h12AF, 4'h0, 4'hF, 1'b0);
    cycles(3 * SWEEP);

    load(16'h0030, 4'h0, 4'hF, 1'b1);
    cycles(2 * SWEEP);
    load(16'h0030, 4'b0100, 4'hF, 1'b1);
    cycles(2 * SWEEP);

    brillo = 2'd0;
    cycles(SWEEP);
    brillo = 2'd1;
    cycles(SWEEP);
    brillo = 2'd3;

    wait_phase(36);
    load(16'h5678, 4'b0010, 4'hF, 1'b0);
    cycles(2 * SWEEP);

    // Load coinciding with the sweep wrap must wait one extra sweep.
    wait_phase(SWEEP - 1);
    load(16'h9ABC, 4'h0, 4'b1011, 1'b0);
    cycles(2 * SWEEP);

    wait_phase(52);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(SWEEP + 10);

    for (int it = 0; it < 60; it++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 4))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        3:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      datos    = 16'($urandom()) & mask;
      puntos   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
      habil    = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
      suprimir = 1'($urandom());
      brillo   = 2'($urandom());
      cargar   = 1'($urandom());
      cycles(1);
      cargar = 1'b0;
      cycles($urandom_range(1, 48));
    end

    cycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/controlador_display_7seg_param.md
Name: controlador_display_7seg_param

Overview:
Parametrised multiplexed driver for NUM_DIGITOS common-anode or common-cathode 7-segment digits. It has an integrated refresh prescaler, hex decode, per-digit decimal points, per-digit enables, leading-zero suppression and PWM brightness control. Input data goes through a shadow register, and the display only updates at sweep boundaries, so no digit tears. It replaces the fixed 4-digit display controller at the top of board-level designs and is driven directly from the board clock.

Parameters:
NUM_DIGITOS, 4, number of multiplexed digits (2..8)
CLK_HZ, 100000000, i_Reloj frequency in Hz
REFRESCO_HZ, 1000, per-digit slot rate in Hz (full sweep = REFRESCO_HZ/NUM_DIGITOS)
BRILLO_BITS, 4, brightness resolution; slot is split into 2^BRILLO_BITS sub-ticks
ANODO_ACTIVO_BAJO, 1, 1 = o_Anodos asserted low
SEG_ACTIVO_BAJO, 1, 1 = o_Segmentos and o_Punto asserted low

Ports:
i_Reloj  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Datos  in  4*NUM_DIGITOS  hex nibble per digit; digit k = bits [4k+3:4k], digit 0 rightmost
i_Puntos  in  NUM_DIGITOS  decimal point per digit, 1 = lit
i_Habilitar_Digito  in  NUM_DIGITOS  1 = digit may be lit
i_Suprimir_Ceros  in  1  1 = blank leading zeros
i_Brillo  in  BRILLO_BITS  duty: (i_Brillo+1)/2^BRILLO_BITS
i_Cargar  in  1  capture i_Datos/i_Puntos/i_Habilitar_Digito/i_Suprimir_Ceros into shadow
o_Segmentos  out  7  bit0=a ... bit6=g, polarity per SEG_ACTIVO_BAJO
o_Punto  out  1  decimal point, polarity per SEG_ACTIVO_BAJO
o_Anodos  out  NUM_DIGITOS  one-hot digit select, polarity per ANODO_ACTIVO_BAJO
o_Fin_Barrido  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset: all counters, digit index, shadow and active registers are 0. Anodes are all inactive, segments and o_Punto are off (after the polarity parameters are applied), and o_Fin_Barrido = 0. Reset mid-sweep aborts immediately on the next edge.
- Prescaler: SUB_DIV = CLK_HZ/(REFRESCO_HZ*2^BRILLO_BITS), integer division. Elaboration error if SUB_DIV < 1. The counter runs 0..SUB_DIV-1, and the wrap generates a sub-tick.
- PWM counter (BRILLO_BITS wide) increments on each sub-tick. Its wrap generates a slot tick, which advances the digit index 0→1→…→NUM_DIGITOS-1→0.
- o_Fin_Barrido pulses for 1 cycle on the slot tick where the index wraps N-1→0.
- Shadow: when i_Cargar=1, shadow ← inputs on that edge; the last i_Cargar wins. The active register ← shadow only on the cycle the index wraps to 0, including when i_Cargar is asserted on that same cycle; in that case the new value is in the shadow but not in the active register until the next sweep.
- Suppression: if the active suppression flag is set, digit k (k≥1) is blanked when its nibble and all nibbles above it are 0. Digit 0 is never suppressed. A lit decimal point on a digit stops suppression at and below that digit.
- Digit k is lit iff its enable is 1, it is not suppressed, and pwm_cnt ≤ i_Brillo. i_Brillo is sampled live, not shadowed.
- Decode, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- When unlit: anode inactive, segments off, point off (ghost-free).
- All outputs are registered. Latency is 1 cycle from the index/PWM change to the pins.
- The anode is driven inactive for the first cycle of every slot (dead time).

Test Plan:
Sim params: CLK_HZ=1600, REFRESCO_HZ=100, BRILLO_BITS=2, N=4, both active-low. This gives SUB_DIV=4, a 16-cycle slot and a 64-cycle sweep.
1. Reset held 3 cycles -> o_Anodos=4'hF, o_Segmentos=7'h7F, o_Punto=1, o_Fin_Barrido=0. After release, o_Fin_Barrido pulses every 64 cycles.
2. Load i_Datos=16'h12AF, all enabled, i_Brillo=3, i_Cargar pulse -> from next sweep: digit0 segments=~7'h71, digit1=~7'h77, digit2=~7'h5B, digit3=~7'h06. Each anode is low for cycles 2-16 of its slot (cycle 1 is dead time).
3. i_Datos=16'h0030, i_Suprimir_Ceros=1 -> digits 3 and 2 are anode-inactive for the whole slot, digit1=~7'h4F, digit0=~7'h3F. Setting i_Puntos[2]=1 relights digit2 as ~7'h3F with o_Punto=0.
4. i_Brillo=0 -> each anode is low for cycles 2-4 of its 16-cycle slot. i_Brillo=1 -> cycles 2-8.
5. Change i_Datos and pulse i_Cargar mid-sweep at digit 2 -> digits 2 and 3 keep the old values until the index wraps, and the new values appear from the following digit-0 slot.
6. Assert reset during digit 3's slot -> next edge: outputs return to reset values, and the sweep restarts at digit 0 with the active data cleared (all segments show 0 if enabled).
